// File: rtl/serial_adder_if.sv
// ---------------------------------------------------------------------------
// serial_adder_if
// Handshake and data bundle between a requester and the bit-serial adder.
//
// Signals:
//   start  requester -> adder   request a new addition
//   a, b   requester -> adder   operands, captured on the accepted start edge
//   busy   adder -> requester   high while bits are being processed
//   done   adder -> requester   one-cycle pulse when sum/cout are fresh
//   sum    adder -> requester   (a+b) mod 2^WIDTH, held until next completion
//   cout   adder -> requester   carry out of the MSB, valid with sum
//
// Modports:
//   master  requester side (drives start, a, b)
//   slave   adder side (drives busy, done, sum, cout)
// ---------------------------------------------------------------------------
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start,
        output a,
        output b,
        input  busy,
        input  done,
        input  sum,
        input  cout
    );

    modport slave (
        input  start,
        input  a,
        input  b,
        output busy,
        output done,
        output sum,
        output cout
    );
endinterface

// File: rtl/serial_adder.sv
// ---------------------------------------------------------------------------
// serial_adder
// Bit-serial WIDTH-bit adder, one bit per clock, LSB first, with a registered
// carry. Rebuilds a minuend from a difference and a subtrahend (A = D + B),
// so it pairs naturally with the subtractor blocks as a checker.
//
// Parameters:
//   WIDTH  operand/result width in bits, legal range 2..32
//
// Ports:
//   clk   input   rising-edge clock
//   rst   input   synchronous, active-high reset
//   bus   slave   serial_adder_if: start/a/b in, busy/done/sum/cout out
//
// Timing: a start accepted at edge k keeps busy high after edges k..k+WIDTH-1,
// and done is high for the single cycle after edge k+WIDTH. Holding start
// high gives one result every WIDTH+1 cycles.
// ---------------------------------------------------------------------------
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    serial_adder_if.slave bus
);

    // One extra counter bit so the count can reach WIDTH after the final
    // bit without wrapping, even at WIDTH=32.
    localparam int              CNT_W    = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    // Partial result: only WIDTH-1 bits need storing, the final bit goes
    // straight from the adder cell into sum on the last edge.
    logic [WIDTH-2:0] res_sh;
    logic             carry;
    logic [CNT_W-1:0] bit_cnt;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;

    logic             accept;
    logic             last_bit;
    logic             sum_bit;
    logic             carry_next;
    logic [WIDTH-1:0] res_full;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. start is only honoured in IDLE or DONE; in DONE it
    // chains straight into the next operation with no idle gap.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_next = RUN;
                    accept     = 1'b1;
                end
            end
            RUN: begin
                if (bit_cnt == LAST_BIT) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (bus.start) begin
                    state_next = RUN;
                    accept     = 1'b1;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // One-bit full adder cell working on the current LSBs.
    always_comb begin
        sum_bit    = a_sh[0] ^ b_sh[0] ^ carry;
        carry_next = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
        res_full   = {sum_bit, res_sh};
        last_bit   = (state == RUN) && (bit_cnt == LAST_BIT);
    end

    // Datapath. Operands shift right so bit 0 is always the bit being added;
    // the result fills in from the MSB side so after WIDTH edges bit 0 of the
    // first sum bit has landed in the LSB position.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh    <= '0;
            b_sh    <= '0;
            res_sh  <= '0;
            carry   <= 1'b0;
            bit_cnt <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else if (accept) begin
            a_sh    <= bus.a;
            b_sh    <= bus.b;
            res_sh  <= '0;
            carry   <= 1'b0;
            bit_cnt <= '0;
        end else if (state == RUN) begin
            a_sh    <= {1'b0, a_sh[WIDTH-1:1]};
            b_sh    <= {1'b0, b_sh[WIDTH-1:1]};
            res_sh  <= res_full[WIDTH-1:1];
            carry   <= carry_next;
            bit_cnt <= bit_cnt + CNT_W'(1);
            // Visible outputs change only on completion so the previous
            // result stays readable while the next one is being built.
            if (last_bit) begin
                sum_q  <= res_full;
                cout_q <= carry_next;
            end
        end
    end

    assign bus.busy = (state == RUN);
    assign bus.done = (state == DONE);
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// ---------------------------------------------------------------------------
// tb_serial_adder
// Self-checking bench for serial_adder at WIDTH=8 (main), WIDTH=4
// (exhaustive inverse-of-subtractor sweep) and WIDTH=32 (counter boundary).
// Expected results come from plain integer addition of the operands.
// ---------------------------------------------------------------------------
module tb_serial_adder;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    serial_adder_if #(.WIDTH(8))  if8 ();
    serial_adder_if #(.WIDTH(4))  if4 ();
    serial_adder_if #(.WIDTH(32)) if32 ();

    serial_adder #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(if8));
    serial_adder #(.WIDTH(4))  dut4  (.clk(clk), .rst(rst), .bus(if4));
    serial_adder #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(if32));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start with the given operands, scramble the operand inputs right
    // after capture, then wait (bounded) for done. lat counts edges after the
    // capturing edge until done is seen.
    task automatic op8(input logic [7:0] av, input logic [7:0] bv,
                       output logic [8:0] res, output int lat);
        if8.a = av; if8.b = bv; if8.start = 1'b1;
        tick();
        if8.start = 1'b0; if8.a = 8'($urandom); if8.b = 8'($urandom);
        lat = 0;
        while (if8.done !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        res = {if8.cout, if8.sum};
    endtask

    task automatic op4(input logic [3:0] av, input logic [3:0] bv,
                       output logic [4:0] res, output int lat);
        if4.a = av; if4.b = bv; if4.start = 1'b1;
        tick();
        if4.start = 1'b0; if4.a = 4'($urandom); if4.b = 4'($urandom);
        lat = 0;
        while (if4.done !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        res = {if4.cout, if4.sum};
    endtask

    task automatic op32(input logic [31:0] av, input logic [31:0] bv,
                        output logic [32:0] res, output int lat);
        if32.a = av; if32.b = bv; if32.start = 1'b1;
        tick();
        if32.start = 1'b0; if32.a = $urandom; if32.b = $urandom;
        lat = 0;
        while (if32.done !== 1'b1 && lat < 60) begin
            tick();
            lat++;
        end
        res = {if32.cout, if32.sum};
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if ({if8.busy, if8.done, if8.cout, if8.sum} !== 11'b0) begin
                errors++;
                $display("[TB] FAIL reset_state cycle %0d: busy=%b done=%b cout=%b sum=%h, expected all zero",
                         i, if8.busy, if8.done, if8.cout, if8.sum);
            end
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({if8.busy, if8.done, if8.cout, if8.sum} !== 11'b0) begin
                errors++;
                $display("[TB] FAIL idle_state cycle %0d: busy=%b done=%b cout=%b sum=%h, expected all zero",
                         i, if8.busy, if8.done, if8.cout, if8.sum);
            end
        end
    endtask

    task automatic test_basic();
        if8.a = 8'h35; if8.b = 8'h4A; if8.start = 1'b1;
        tick();
        if8.start = 1'b0; if8.a = 8'hC3; if8.b = 8'h99;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (if8.busy !== 1'b1 || if8.done !== 1'b0) begin
                errors++;
                $display("[TB] FAIL basic_busy step %0d: busy=%b done=%b, expected busy=1 done=0",
                         i, if8.busy, if8.done);
            end
            checks++;
            if (if8.sum !== 8'h00) begin
                errors++;
                $display("[TB] FAIL basic_hold step %0d: sum=%h, expected previous 00", i, if8.sum);
            end
            tick();
        end
        checks++;
        if (if8.done !== 1'b1 || if8.busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL basic_done: done=%b busy=%b, expected done=1 busy=0", if8.done, if8.busy);
        end
        checks++;
        if ({if8.cout, if8.sum} !== 9'h07F) begin
            errors++;
            $display("[TB] FAIL basic_result: cout=%b sum=%h, expected cout=0 sum=7f", if8.cout, if8.sum);
        end
        tick();
        checks++;
        if (if8.done !== 1'b0 || if8.busy !== 1'b0 || if8.sum !== 8'h7F) begin
            errors++;
            $display("[TB] FAIL basic_after: done=%b busy=%b sum=%h, expected done=0 busy=0 sum=7f",
                     if8.done, if8.busy, if8.sum);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] av [5] = '{8'hFF, 8'h80, 8'h00, 8'h01, 8'h7F};
        logic [7:0] bv [5] = '{8'hFF, 8'h80, 8'h00, 8'hFF, 8'h01};
        logic [8:0] res;
        logic [8:0] exp;
        int         lat;
        for (int i = 0; i < 5; i++) begin
            op8(av[i], bv[i], res, lat);
            exp = {1'b0, av[i]} + {1'b0, bv[i]};
            checks++;
            if (res !== exp || lat != 8) begin
                errors++;
                $display("[TB] FAIL overflow %h+%h: got cout,sum=%h lat=%0d, expected %h lat=8",
                         av[i], bv[i], res, lat, exp);
            end
        end
    endtask

    task automatic test_random8();
        logic [7:0] av, bv;
        logic [8:0] res;
        int         lat;
        for (int i = 0; i < 30; i++) begin
            av = 8'($urandom);
            bv = 8'($urandom);
            op8(av, bv, res, lat);
            checks++;
            if (res !== ({1'b0, av} + {1'b0, bv}) || lat != 8) begin
                errors++;
                $display("[TB] FAIL random8 %h+%h: got %h lat=%0d, expected %h lat=8",
                         av, bv, res, lat, {1'b0, av} + {1'b0, bv});
            end
        end
        if8.start = 1'b0;
        tick();
    endtask

    task automatic test_inverse4();
        logic [3:0] d;
        logic [4:0] res;
        logic [4:0] exp;
        int         lat;
        for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
                d   = 4'((ai - bi) & 15);
                op4(d, 4'(bi), res, lat);
                exp = {1'b0, d} + 5'(bi);
                checks++;
                if (res[3:0] !== 4'(ai) || res[4] !== exp[4] || lat != 4) begin
                    errors++;
                    $display("[TB] FAIL inverse4 A=%0d B=%0d: got sum=%0d cout=%b lat=%0d, expected sum=%0d cout=%b lat=4",
                             ai, bi, res[3:0], res[4], lat, ai, exp[4]);
                end
            end
        end
        tick();
    endtask

    task automatic test_width32();
        logic [31:0] av, bv;
        logic [32:0] res;
        int          lat;
        for (int i = 0; i < 6; i++) begin
            if (i == 0) begin
                av = 32'h0; bv = 32'h0;
            end else if (i == 1) begin
                av = 32'hFFFF_FFFF; bv = 32'hFFFF_FFFF;
            end else begin
                av = $urandom; bv = $urandom;
            end
            op32(av, bv, res, lat);
            checks++;
            if (res !== ({1'b0, av} + {1'b0, bv}) || lat != 32) begin
                errors++;
                $display("[TB] FAIL width32 %h+%h: got %h lat=%0d, expected %h lat=32",
                         av, bv, res, lat, {1'b0, av} + {1'b0, bv});
            end
        end
        tick();
    endtask

    task automatic test_ignore_start();
        logic [7:0] a1, b1;
        int         lat;
        a1 = 8'hA7; b1 = 8'h6E;
        if8.a = a1; if8.b = b1; if8.start = 1'b1;
        tick();
        if8.start = 1'b0;
        lat = 0;
        while (if8.done !== 1'b1 && lat < 40) begin
            if8.start = (lat == 2 || lat == 5);
            if8.a = 8'($urandom); if8.b = 8'($urandom);
            tick();
            lat++;
        end
        if8.start = 1'b0;
        checks++;
        if ({if8.cout, if8.sum} !== ({1'b0, a1} + {1'b0, b1}) || lat != 8) begin
            errors++;
            $display("[TB] FAIL ignore_start: got %h lat=%0d, expected %h lat=8",
                     {if8.cout, if8.sum}, lat, {1'b0, a1} + {1'b0, b1});
        end
        tick();
        checks++;
        if (if8.done !== 1'b0 || if8.busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ignore_start_idle: done=%b busy=%b, expected 0 0", if8.done, if8.busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] av [64];
        logic [7:0] bv [64];
        logic [8:0] exp;
        int         next_acc;
        int         n_done;
        logic       overlap;
        next_acc = 0;
        n_done   = 0;
        overlap  = 1'b0;
        for (int i = 0; i < 46; i++) begin
            av[i] = 8'($urandom);
            bv[i] = 8'($urandom);
            if8.a = av[i]; if8.b = bv[i];
            if8.start = (i < 30);
            tick();
            if (if8.busy === 1'b1 && if8.done === 1'b1) overlap = 1'b1;
            if (if8.done === 1'b1) begin
                n_done++;
                exp = {1'b0, av[next_acc]} + {1'b0, bv[next_acc]};
                checks++;
                if (i != next_acc + 8 || {if8.cout, if8.sum} !== exp) begin
                    errors++;
                    $display("[TB] FAIL b2b_result edge %0d: got %h, expected %h at edge %0d",
                             i, {if8.cout, if8.sum}, exp, next_acc + 8);
                end
                next_acc = i + 1;
            end
        end
        if8.start = 1'b0;
        checks++;
        if (n_done != 4) begin
            errors++;
            $display("[TB] FAIL b2b_count: got %0d done pulses, expected 4", n_done);
        end
        checks++;
        if (overlap !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_overlap: busy and done seen together=%b, expected 0", overlap);
        end
    endtask

    task automatic test_reset_mid();
        logic [8:0] res;
        int         lat;
        logic       done_seen;
        op8(8'h12, 8'h34, res, lat);
        if8.a = 8'h55; if8.b = 8'h66; if8.start = 1'b1;
        tick();
        if8.start = 1'b0;
        repeat (3) tick();
        checks++;
        if (if8.busy !== 1'b1 || if8.sum !== 8'h46) begin
            errors++;
            $display("[TB] FAIL rstmid_pre: busy=%b sum=%h, expected busy=1 sum=46", if8.busy, if8.sum);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({if8.busy, if8.done, if8.cout, if8.sum} !== 11'b0) begin
            errors++;
            $display("[TB] FAIL rstmid_clear: busy=%b done=%b cout=%b sum=%h, expected all zero",
                     if8.busy, if8.done, if8.cout, if8.sum);
        end
        done_seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (if8.done === 1'b1 || if8.busy === 1'b1) done_seen = 1'b1;
        end
        checks++;
        if (done_seen !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rstmid_discard: activity after reset=%b, expected 0", done_seen);
        end
        op8(8'h9A, 8'h0C, res, lat);
        checks++;
        if (res !== 9'h0A6 || lat != 8) begin
            errors++;
            $display("[TB] FAIL rstmid_after: got %h lat=%0d, expected 0a6 lat=8", res, lat);
        end
    endtask

    initial begin
        rst = 1'b1;
        if8.start = 1'b0;  if8.a = '0;  if8.b = '0;
        if4.start = 1'b0;  if4.a = '0;  if4.b = '0;
        if32.start = 1'b0; if32.a = '0; if32.b = '0;
        test_reset();
        test_basic();
        test_overflow();
        test_random8();
        test_inverse4();
        test_width32();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
